// File: rtl/square_channel_v2_pkg.sv
// Shared definitions for the pulse channels and their successors.
// Contents: default field widths, duty-select enum, 8-step duty table and lookup helper.
// Configuration macro honoured by users of this package: SQ_SIGNED_OUT_EN.
package square_channel_v2_pkg;

    localparam int unsigned DEF_FREQ_W = 11;
    localparam int unsigned DEF_LEN_W  = 6;
    localparam int unsigned DEF_VOL_W  = 4;

    typedef enum logic [1:0] {
        DutyEighth       = 2'd0,
        DutyQuarter      = 2'd1,
        DutyHalf         = 2'd2,
        DutyThreeQuarter = 2'd3
    } duty_e;

    // Entry [d] is the waveform for duty select d; bit[pos] is output at step pos (LSB first).
    localparam logic [3:0][7:0] DUTY_TABLE = {
        8'b0111_1110,
        8'b1110_0001,
        8'b1000_0001,
        8'b1000_0000
    };

    function automatic logic duty_bit(duty_e duty, logic [2:0] pos);
        return DUTY_TABLE[duty][pos];
    endfunction

endpackage

// File: rtl/square_channel_v2_if.sv
// Register-file / mixer side bundle of one pulse channel.
// master: register file + mixer (drives ticks, trigger and register fields, reads level/active).
// slave : the channel itself.
// Macro SQ_SIGNED_OUT_EN widens level to a signed VOL_W+1 bit sample.
interface square_channel_v2_if
    import square_channel_v2_pkg::*;
#(
    parameter int unsigned FREQ_W = DEF_FREQ_W,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned VOL_W  = DEF_VOL_W
);
    logic              freq_tick;
    logic              length_tick;
    logic              sweep_tick;
    logic              env_tick;
    logic              trigger;
    logic              length_enable;
    logic [LEN_W-1:0]  length_data;
    logic [1:0]        wave_duty;
    logic [VOL_W-1:0]  initial_volume;
    logic              envelope_increasing;
    logic [2:0]        envelope_period;
    logic [2:0]        sweep_period;
    logic              sweep_decreasing;
    logic [2:0]        sweep_shift;
    logic [FREQ_W-1:0] frequency_data;
`ifdef SQ_SIGNED_OUT_EN
    logic signed [VOL_W:0] level;
`else
    logic [VOL_W-1:0]      level;
`endif
    logic              active;

    modport master (
        output freq_tick, length_tick, sweep_tick, env_tick, trigger, length_enable,
               length_data, wave_duty, initial_volume, envelope_increasing, envelope_period,
               sweep_period, sweep_decreasing, sweep_shift, frequency_data,
        input  level, active
    );

    modport slave (
        input  freq_tick, length_tick, sweep_tick, env_tick, trigger, length_enable,
               length_data, wave_duty, initial_volume, envelope_increasing, envelope_period,
               sweep_period, sweep_decreasing, sweep_shift, frequency_data,
        output level, active
    );
endinterface

// File: rtl/square_channel_v2_sq_sweep_unit.sv
// Frequency sweep unit of pulse channel 1.
// Ports: clk/reset; trigger and sweep_tick enables; sweep_period/decreasing/shift controls;
// frequency_data (loaded at trigger); shadow_freq (current swept frequency);
// overflow (combinational pulse in the cycle whose edge must clear the channel).
module sq_sweep_unit #(
    parameter int unsigned FREQ_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trigger,
    input  logic              sweep_tick,
    input  logic [2:0]        sweep_period,
    input  logic              sweep_decreasing,
    input  logic [2:0]        sweep_shift,
    input  logic [FREQ_W-1:0] frequency_data,
    output logic [FREQ_W-1:0] shadow_freq,
    output logic              overflow
);
    logic [FREQ_W-1:0] shadow_q, shadow_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [FREQ_W:0]   n_sum;
    logic [FREQ_W:0]   trig_sum;

    always_comb begin
        // One extra bit so an add that passes 2^FREQ_W-1 is visible in the MSB.
        n_sum = sweep_decreasing
              ? {1'b0, shadow_q} - {1'b0, shadow_q >> sweep_shift}
              : {1'b0, shadow_q} + {1'b0, shadow_q >> sweep_shift};
        trig_sum = {1'b0, frequency_data} + {1'b0, frequency_data >> sweep_shift};

        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        overflow = 1'b0;
        if (trigger) begin
            shadow_d = frequency_data;
            cnt_d    = sweep_period;
            overflow = !sweep_decreasing && (sweep_shift != 3'd0) && trig_sum[FREQ_W];
        end else if (sweep_tick && (sweep_period != 3'd0)) begin
            if (cnt_q <= 3'd1) begin
                cnt_d = sweep_period;
                if (!sweep_decreasing && n_sum[FREQ_W]) begin
                    overflow = 1'b1;
                end else if (sweep_shift != 3'd0) begin
                    shadow_d = n_sum[FREQ_W-1:0];
                end
            end else begin
                cnt_d = cnt_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign shadow_freq = shadow_q;

endmodule

// File: rtl/square_channel_v2.sv
// Gameboy pulse channel (CH1 with HAS_SWEEP=1, CH2 with HAS_SWEEP=0), single clock domain.
// Ports: ac97_bitclk (clock), reset (sync, active-high), bus (slave side of
// square_channel_v2_if: tick enables, trigger, register fields in; level, active out).
// Macro SQ_SIGNED_OUT_EN: level is signed +vol/-vol instead of unsigned vol/0.
module square_channel_v2
    import square_channel_v2_pkg::*;
#(
    parameter int unsigned FREQ_W    = DEF_FREQ_W,
    parameter int unsigned LEN_W     = DEF_LEN_W,
    parameter int unsigned VOL_W     = DEF_VOL_W,
    parameter int unsigned HAS_SWEEP = 1
) (
    input logic                 ac97_bitclk,
    input logic                 reset,
    square_channel_v2_if.slave  bus
);
    localparam logic [FREQ_W:0] FREQ_FULL = {1'b1, {FREQ_W{1'b0}}};
    localparam logic [LEN_W:0]  LEN_FULL  = {1'b1, {LEN_W{1'b0}}};

    logic [FREQ_W:0]   timer_q, timer_d;
    logic [2:0]        duty_pos_q, duty_pos_d;
    logic [VOL_W-1:0]  vol_q, vol_d;
    logic [2:0]        env_cnt_q, env_cnt_d;
    logic [LEN_W:0]    len_q, len_d;
    logic              active_q, active_d;
`ifdef SQ_SIGNED_OUT_EN
    logic signed [VOL_W:0] level_q, level_d;
`else
    logic [VOL_W-1:0]      level_q, level_d;
`endif
    logic [FREQ_W-1:0] reload_src;
    logic              sweep_overflow;
    logic              dac_off;
    logic              duty_high;

    if (HAS_SWEEP != 0) begin : g_sweep
        sq_sweep_unit #(
            .FREQ_W (FREQ_W)
        ) u_sweep (
            .clk              (ac97_bitclk),
            .reset            (reset),
            .trigger          (bus.trigger),
            .sweep_tick       (bus.sweep_tick),
            .sweep_period     (bus.sweep_period),
            .sweep_decreasing (bus.sweep_decreasing),
            .sweep_shift      (bus.sweep_shift),
            .frequency_data   (bus.frequency_data),
            .shadow_freq      (reload_src),
            .overflow         (sweep_overflow)
        );
    end else begin : g_no_sweep
        assign reload_src     = bus.frequency_data;
        assign sweep_overflow = 1'b0;
    end

    assign dac_off   = (bus.initial_volume == '0) && !bus.envelope_increasing;
    assign duty_high = duty_bit(duty_e'(bus.wave_duty), duty_pos_q);

    always_comb begin
        timer_d    = timer_q;
        duty_pos_d = duty_pos_q;
        vol_d      = vol_q;
        env_cnt_d  = env_cnt_q;
        len_d      = len_q;
        active_d   = active_q;

        if (bus.trigger) begin
            active_d  = 1'b1;
            timer_d   = FREQ_FULL - {1'b0, bus.frequency_data};
            vol_d     = bus.initial_volume;
            env_cnt_d = bus.envelope_period;
            len_d     = LEN_FULL - {1'b0, bus.length_data};
        end else begin
            if (bus.freq_tick) begin
                // timer==0 only occurs straight out of reset; treat it as a reload point.
                if (timer_q <= (FREQ_W+1)'(1)) begin
                    timer_d    = FREQ_FULL - {1'b0, reload_src};
                    duty_pos_d = duty_pos_q + 3'd1;
                end else begin
                    timer_d = timer_q - (FREQ_W+1)'(1);
                end
            end
            if (bus.length_tick && bus.length_enable && (len_q != '0)) begin
                len_d = len_q - (LEN_W+1)'(1);
                if (len_q == (LEN_W+1)'(1)) begin
                    active_d = 1'b0;
                end
            end
            if (bus.env_tick && (bus.envelope_period != 3'd0)) begin
                if (env_cnt_q <= 3'd1) begin
                    env_cnt_d = bus.envelope_period;
                    if (bus.envelope_increasing) begin
                        if (vol_q != '1) vol_d = vol_q + VOL_W'(1);
                    end else begin
                        if (vol_q != '0) vol_d = vol_q - VOL_W'(1);
                    end
                end else begin
                    env_cnt_d = env_cnt_q - 3'd1;
                end
            end
        end

        if (sweep_overflow || dac_off) begin
            active_d = 1'b0;
        end

        // Output is built from the current state, so it trails the causing event by one edge.
`ifdef SQ_SIGNED_OUT_EN
        if (!active_q)      level_d = '0;
        else if (duty_high) level_d = {1'b0, vol_q};
        else                level_d = -{1'b0, vol_q};
`else
        level_d = (active_q && duty_high) ? vol_q : '0;
`endif
    end

    always_ff @(posedge ac97_bitclk) begin
        if (reset) begin
            timer_q    <= '0;
            duty_pos_q <= '0;
            vol_q      <= '0;
            env_cnt_q  <= '0;
            len_q      <= '0;
            active_q   <= 1'b0;
            level_q    <= '0;
        end else begin
            timer_q    <= timer_d;
            duty_pos_q <= duty_pos_d;
            vol_q      <= vol_d;
            env_cnt_q  <= env_cnt_d;
            len_q      <= len_d;
            active_q   <= active_d;
            level_q    <= level_d;
        end
    end

    assign bus.level  = level_q;
    assign bus.active = active_q;

endmodule

// File: tb/tb_square_channel_v2.sv
// Directed self-checking bench for square_channel_v2 (default build, CH1 with sweep).
module tb_square_channel_v2;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    square_channel_v2_if #(.FREQ_W(11), .LEN_W(6), .VOL_W(4)) bus ();

    square_channel_v2 #(
        .FREQ_W    (11),
        .LEN_W     (6),
        .VOL_W     (4),
        .HAS_SWEEP (1)
    ) dut (
        .ac97_bitclk (clk),
        .reset       (reset),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [1:0] duty, input logic [3:0] vol, input logic inc,
                         input logic [2:0] eper, input logic len_en, input logic [5:0] ldata,
                         input logic [10:0] freq, input logic [2:0] sper, input logic sdec,
                         input logic [2:0] sshift);
        bus.wave_duty           = duty;
        bus.initial_volume      = vol;
        bus.envelope_increasing = inc;
        bus.envelope_period     = eper;
        bus.length_enable       = len_en;
        bus.length_data         = ldata;
        bus.frequency_data      = freq;
        bus.sweep_period        = sper;
        bus.sweep_decreasing    = sdec;
        bus.sweep_shift         = sshift;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_trigger();
        bus.trigger = 1'b1;
        tick();
        bus.trigger = 1'b0;
    endtask

    task automatic pulse_length();
        bus.length_tick = 1'b1;
        tick();
        bus.length_tick = 1'b0;
    endtask

    task automatic pulse_sweep();
        bus.sweep_tick = 1'b1;
        tick();
        bus.sweep_tick = 1'b0;
    endtask

    // One envelope step plus one idle edge so level shows the new volume.
    task automatic env_step();
        bus.env_tick = 1'b1;
        tick();
        bus.env_tick = 1'b0;
        tick();
    endtask

    logic [3:0] duty2_pat [8];

    initial begin
        n_cmp = 0;
        n_err = 0;
        duty2_pat = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF};
        bus.freq_tick   = 1'b0;
        bus.length_tick = 1'b0;
        bus.sweep_tick  = 1'b0;
        bus.env_tick    = 1'b0;
        bus.trigger     = 1'b0;
        setup(2'd0, 4'h0, 1'b0, 3'd0, 1'b0, 6'd0, 11'd0, 3'd0, 1'b0, 3'd0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_level", 32'(bus.level), 32'h0);
        check("reset_active", 32'(bus.active), 32'h0);

        // Duty 2 at freq 2047: duty step advances on every freq_tick.
        setup(2'd2, 4'hF, 1'b0, 3'd0, 1'b0, 6'd0, 11'd2047, 3'd0, 1'b0, 3'd0);
        pulse_trigger();
        check("duty_active_after_trigger", 32'(bus.active), 32'h1);
        bus.freq_tick = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check($sformatf("duty_level_step%0d", i), 32'(bus.level), 32'(duty2_pat[i % 8]));
        end
        bus.freq_tick = 1'b0;
        check("duty_active_hold", 32'(bus.active), 32'h1);

        // Length 62 -> two ticks to expiry.
        do_reset();
        setup(2'd2, 4'hF, 1'b0, 3'd0, 1'b1, 6'd62, 11'd0, 3'd0, 1'b0, 3'd0);
        pulse_trigger();
        tick();
        check("len_level_playing", 32'(bus.level), 32'hF);
        pulse_length();
        check("len_active_after_tick1", 32'(bus.active), 32'h1);
        pulse_length();
        check("len_active_after_tick2", 32'(bus.active), 32'h0);
        check("len_level_lags", 32'(bus.level), 32'hF);
        tick();
        check("len_level_silenced", 32'(bus.level), 32'h0);

        // Envelope down from 2, then up from E.
        do_reset();
        setup(2'd2, 4'h2, 1'b0, 3'd1, 1'b0, 6'd0, 11'd0, 3'd0, 1'b0, 3'd0);
        pulse_trigger();
        tick();
        check("env_dn_start", 32'(bus.level), 32'h2);
        env_step();
        check("env_dn_1", 32'(bus.level), 32'h1);
        env_step();
        check("env_dn_0", 32'(bus.level), 32'h0);
        env_step();
        check("env_dn_hold0", 32'(bus.level), 32'h0);
        check("env_dn_active", 32'(bus.active), 32'h1);
        do_reset();
        setup(2'd2, 4'hE, 1'b1, 3'd1, 1'b0, 6'd0, 11'd0, 3'd0, 1'b0, 3'd0);
        pulse_trigger();
        tick();
        check("env_up_start", 32'(bus.level), 32'hE);
        env_step();
        check("env_up_F", 32'(bus.level), 32'hF);
        env_step();
        check("env_up_sat", 32'(bus.level), 32'hF);

        // Sweep: trigger-time overflow, then stepwise growth 0x400->0x500->0x640->0x7D0->ovf.
        do_reset();
        setup(2'd2, 4'hF, 1'b0, 3'd0, 1'b0, 6'd0, 11'h700, 3'd1, 1'b0, 3'd1);
        pulse_trigger();
        check("sweep_trig_ovf_shift1", 32'(bus.active), 32'h0);
        bus.sweep_shift = 3'd2;
        pulse_trigger();
        check("sweep_trig_ovf_shift2", 32'(bus.active), 32'h0);
        bus.frequency_data = 11'h400;
        pulse_trigger();
        check("sweep_trig_ok", 32'(bus.active), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            pulse_sweep();
            check($sformatf("sweep_step%0d_active", i), 32'(bus.active), 32'h1);
        end
        pulse_sweep();
        check("sweep_step4_overflow", 32'(bus.active), 32'h0);

        // DAC off: trigger cannot start the channel.
        do_reset();
        setup(2'd2, 4'h0, 1'b0, 3'd0, 1'b0, 6'd0, 11'd0, 3'd0, 1'b0, 3'd0);
        pulse_trigger();
        check("dac_off_active", 32'(bus.active), 32'h0);
        tick();
        check("dac_off_level", 32'(bus.level), 32'h0);
        bus.initial_volume = 4'hF;
        tick();
        check("dac_on_no_trigger", 32'(bus.active), 32'h0);

        // Trigger beats a same-cycle length tick; full load of 2 remains.
        do_reset();
        setup(2'd2, 4'hF, 1'b0, 3'd0, 1'b1, 6'd62, 11'd0, 3'd0, 1'b0, 3'd0);
        bus.length_tick = 1'b1;
        pulse_trigger();
        bus.length_tick = 1'b0;
        check("prio_active_after_trig", 32'(bus.active), 32'h1);
        pulse_length();
        check("prio_active_len1", 32'(bus.active), 32'h1);
        pulse_length();
        check("prio_active_len0", 32'(bus.active), 32'h0);

        // Reset mid-note.
        bus.length_enable = 1'b0;
        pulse_trigger();
        tick();
        check("midnote_level", 32'(bus.level), 32'hF);
        do_reset();
        check("midreset_level", 32'(bus.level), 32'h0);
        check("midreset_active", 32'(bus.active), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
